ripple_count_monitor: RTL and testbench
=======================================

Name: ripple_count_monitor

Overview:
- Downstream consumer of the 4-bit ripple carry counter output `q`.
- That output changes asynchronously, with bit-to-bit ripple skew, relative to the system clock.
- This block synchronizes and de-glitches the raw count into the `clk` domain and extends it with a wrap counter to form a wide count.
- It also flags wraps, threshold matches, skipped/backward steps and extension overflow, for use by downstream control logic.

Parameters:
- WIDTH, 4: width of raw ripple count input.
- EXT_WIDTH, 8: width of wrap-extension counter (upper bits of count_out).
- STABLE_CYCLES, 2: consecutive equal synchronized samples required before a value is accepted (legal range 1..8).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- q_in  input  WIDTH  raw ripple counter output, asynchronous to clk.
- enable  input  1  1 = accept new values; 0 = freeze accepted count.
- cmp_val  input  WIDTH+EXT_WIDTH  match threshold for count_out.
- clr_err  input  1  synchronous clear of step_err and ovf_err.
- count_out  output  WIDTH+EXT_WIDTH  {ext, accepted}, registered.
- count_valid  output  1  high once a first value has been accepted.
- wrap_pulse  output  1  one-cycle pulse when low field wraps.
- match_pulse  output  1  one-cycle pulse when count_out updates to cmp_val.
- step_err  output  1  sticky: accepted increment was not +1 (mod 2^WIDTH).
- ovf_err  output  1  sticky: ext counter wrapped from all-ones to 0.

Behaviour:
- Reset (async, active-high): sync1, sync2, history, accepted, ext, count_valid, wrap_pulse, match_pulse, step_err and ovf_err all go to 0 immediately. Deassertion is taken at the next rising edge. A reset asserted mid-operation discards any pending acceptance.
- Synchronizer: 2-flop chain sync1 -> sync2 on q_in. No other logic samples q_in.
- Stability filter:
  - Keep the last STABLE_CYCLES values of sync2.
  - Candidate is valid when all kept values are equal and differ from accepted, or count_valid=0.
  - Registers update on the next edge.
  - Latency: q_in stable before edge N -> count_out updated after edge N+1+STABLE_CYCLES (N+3 at default).
  - Any change in sync2 inside the window restarts the window.
- enable=0: no acceptance; synchronizer and filter keep running. On re-enable, the next acceptance is a normal step, measured from the frozen accepted value.
- First acceptance (count_valid=0):
  - Load accepted with the candidate and set count_valid=1.
  - No wrap check, step check or ext change.
  - match_pulse still evaluated.
- Normal acceptance, with delta = (new - old) mod 2^WIDTH:
  - new < old numerically: ext <= ext+1 and wrap_pulse=1 for one cycle.
  - ext all-ones -> 0: ovf_err set.
  - delta != 1: step_err set. The value is still accepted and wrap is still applied.
- match_pulse: 1 for exactly the cycle in which the newly registered count_out equals cmp_val. It is not re-asserted while count_out holds. A cmp_val change alone never pulses.
- Pulse alignment: wrap_pulse and match_pulse are registered and coincide with the count_out update cycle.
- clr_err: clears step_err and ovf_err at the next edge. If a new error occurs in the same cycle, set wins.
- Hold: all outputs are otherwise stable.

Test Plan:
- Reset then q_in=0 held: count_valid=1 and count_out=0 at edge 3. No pulses, no errors.
- q_in steps 0..15 then 0, each held for 6 cycles: count_out 0..15 then 16 (ext=1, low=0). wrap_pulse exactly once at the 15->0 acceptance; step_err=0.
- With count_out=0x005, q_in glitches 5->7->6 with only 1 cycle at 7: 7 never accepted; 6 accepted 3 edges after settling; step_err stays 0.
- From low=3, q_in jumps to 6: count_out=0x006 and step_err=1. clr_err pulse -> step_err=0. clr_err coincident with a new bad step -> step_err stays 1.
- cmp_val=0x012, count 0x00F->0x010->0x011->0x012: match_pulse one cycle, aligned with count_out=0x012. Holding 0x012 gives no further pulse.
- ext=0xFF with low 15->0: count_out=0x000, wrap_pulse=1 and ovf_err=1. Async reset asserted mid-window: all outputs 0 immediately, with no acceptance after release until a fresh full window.

Source files
------------

// File: rtl/ripple_count_monitor_if.sv
// ripple_count_monitor_if: bundles the ripple-count monitor's data and
// status signals.
//   q_in        raw ripple counter value, asynchronous to clk
//   enable      1 = new values may be accepted, 0 = accepted count is frozen
//   cmp_val     match threshold compared against count_out
//   clr_err     synchronous clear of the sticky error flags
//   count_out   {ext, accepted} wide count
//   count_valid first value has been accepted
//   wrap_pulse  one-cycle pulse when the low field wraps
//   match_pulse one-cycle pulse when count_out updates to cmp_val
//   step_err    sticky: an accepted step was not +1
//   ovf_err     sticky: the extension counter overflowed
// master = producer/consumer side, slave = monitor side.
interface ripple_count_monitor_if #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned EXT_WIDTH = 8
);
    logic [WIDTH-1:0]           q_in;
    logic                       enable;
    logic [WIDTH+EXT_WIDTH-1:0] cmp_val;
    logic                       clr_err;
    logic [WIDTH+EXT_WIDTH-1:0] count_out;
    logic                       count_valid;
    logic                       wrap_pulse;
    logic                       match_pulse;
    logic                       step_err;
    logic                       ovf_err;

    modport master (
        output q_in, enable, cmp_val, clr_err,
        input  count_out, count_valid, wrap_pulse, match_pulse, step_err, ovf_err
    );

    modport slave (
        input  q_in, enable, cmp_val, clr_err,
        output count_out, count_valid, wrap_pulse, match_pulse, step_err, ovf_err
    );
endinterface

// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor: synchronizes and de-glitches a raw ripple counter
// value into the clk domain, extends it with a wrap counter, and flags
// wraps, threshold matches, non-unit steps and extension overflow.
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    ripple_count_monitor_if slave modport (q_in, enable, cmp_val,
//          clr_err in; count_out, count_valid, wrap_pulse, match_pulse,
//          step_err, ovf_err out)
module ripple_count_monitor #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned EXT_WIDTH     = 8,
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    ripple_count_monitor_if.slave bus
);

    // Synchronizer and stability window. win[0] is the second synchronizer
    // flop; win[1..] hold older sync2 samples.
    logic [WIDTH-1:0]         sync1;
    logic [WIDTH-1:0]         win [STABLE_CYCLES];
    // Valid bits travel alongside the data so that reset values never
    // count as real samples: a full window must refill after reset.
    logic                     sync1_vld;
    logic [STABLE_CYCLES-1:0] win_vld;

    logic [WIDTH-1:0]     accepted;
    logic [EXT_WIDTH-1:0] ext;
    logic                 count_valid;
    logic                 wrap_pulse;
    logic                 match_pulse;
    logic                 step_err;
    logic                 ovf_err;

    logic                 window_same;
    logic                 candidate;
    logic                 accept;
    logic                 accept_normal;
    logic [WIDTH-1:0]     new_val;
    logic [WIDTH-1:0]     delta;
    logic                 wraps;
    logic                 bad_step;
    logic                 ovf_now;
    logic [EXT_WIDTH-1:0] ext_next;
    logic                 hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sync1_vld <= 1'b0;
            win_vld   <= '0;
            for (int unsigned i = 0; i < STABLE_CYCLES; i++) begin
                win[i] <= '0;
            end
        end else begin
            sync1      <= bus.q_in;
            sync1_vld  <= 1'b1;
            win[0]     <= sync1;
            win_vld[0] <= sync1_vld;
            for (int unsigned i = 1; i < STABLE_CYCLES; i++) begin
                win[i]     <= win[i-1];
                win_vld[i] <= win_vld[i-1];
            end
        end
    end

    always_comb begin
        window_same = 1'b1;
        for (int unsigned i = 1; i < STABLE_CYCLES; i++) begin
            if (win[i] != win[0]) begin
                window_same = 1'b0;
            end
        end
    end

    always_comb begin
        new_val       = win[0];
        candidate     = (&win_vld) && window_same &&
                        (!count_valid || (new_val != accepted));
        accept        = candidate && bus.enable;
        accept_normal = accept && count_valid;
        delta         = new_val - accepted;
        // A numerically smaller value means the low field rolled over.
        wraps         = accept_normal && (new_val < accepted);
        bad_step      = accept_normal && (delta != WIDTH'(1));
        ovf_now       = wraps && (&ext);
        ext_next      = wraps ? ext + 1'b1 : ext;
        hit           = accept && ({ext_next, new_val} == bus.cmp_val);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accepted    <= '0;
            ext         <= '0;
            count_valid <= 1'b0;
            wrap_pulse  <= 1'b0;
            match_pulse <= 1'b0;
            step_err    <= 1'b0;
            ovf_err     <= 1'b0;
        end else begin
            wrap_pulse  <= wraps;
            match_pulse <= hit;
            if (accept) begin
                accepted    <= new_val;
                ext         <= ext_next;
                count_valid <= 1'b1;
            end
            // A new error in the clearing cycle takes priority over clr_err.
            if (bad_step) begin
                step_err <= 1'b1;
            end else if (bus.clr_err) begin
                step_err <= 1'b0;
            end
            if (ovf_now) begin
                ovf_err <= 1'b1;
            end else if (bus.clr_err) begin
                ovf_err <= 1'b0;
            end
        end
    end

    assign bus.count_out   = {ext, accepted};
    assign bus.count_valid = count_valid;
    assign bus.wrap_pulse  = wrap_pulse;
    assign bus.match_pulse = match_pulse;
    assign bus.step_err    = step_err;
    assign bus.ovf_err     = ovf_err;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// tb_ripple_count_monitor: drives ripple_count_monitor with directed and
// random q_in sequences and compares every cycle against a reference model
// built from the recorded per-edge q_in sample history.
module tb_ripple_count_monitor;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned EXTW   = 8;
    localparam int unsigned STABLE = 2;

    logic clk = 1'b0;
    logic reset;

    ripple_count_monitor_if #(.WIDTH(WIDTH), .EXT_WIDTH(EXTW)) bus ();

    ripple_count_monitor #(
        .WIDTH(WIDTH),
        .EXT_WIDTH(EXTW),
        .STABLE_CYCLES(STABLE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int samp[$];          // q_in seen at each rising edge since reset release
    int m_valid, m_low, m_ext, m_step, m_ovf, m_wrap, m_match;
    int wrap_seen, match_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        samp.delete();
        m_valid = 0; m_low = 0; m_ext = 0;
        m_step = 0; m_ovf = 0; m_wrap = 0; m_match = 0;
    endtask

    // Called right after a rising edge; inputs only change later in the
    // cycle, so the values read here are those the edge saw.
    task automatic model_edge();
        int t, v, same, cand, step_set, ovf_set, delta;
        if (reset) return;
        samp.push_back(int'(bus.q_in));
        t = samp.size() - 1;
        m_wrap = 0; m_match = 0; step_set = 0; ovf_set = 0; cand = 0; v = 0;
        // Value entering the filter at edge t-1 was sampled at edge t-2;
        // the window needs STABLE consecutive real samples ending there.
        if (t >= int'(STABLE) + 1) begin
            v = samp[t-2];
            same = 1;
            for (int j = 1; j < int'(STABLE); j++)
                if (samp[t-2-j] != v) same = 0;
            cand = same && (!m_valid || v != m_low);
        end
        if (cand && bus.enable) begin
            if (!m_valid) begin
                m_valid = 1;
            end else begin
                if (v < m_low) begin
                    m_wrap = 1;
                    if (m_ext == 255) ovf_set = 1;
                    m_ext = (m_ext + 1) % 256;
                end
                delta = (v - m_low + 16) % 16;
                if (delta != 1) step_set = 1;
            end
            m_low = v;
            m_match = ((m_ext * 16 + m_low) == int'(bus.cmp_val));
        end
        if (step_set) m_step = 1; else if (bus.clr_err) m_step = 0;
        if (ovf_set)  m_ovf  = 1; else if (bus.clr_err) m_ovf  = 0;
    endtask

    task automatic check_all();
        check("count_out",   32'(bus.count_out),   32'(m_ext * 16 + m_low));
        check("count_valid", 32'(bus.count_valid), 32'(m_valid));
        check("wrap_pulse",  32'(bus.wrap_pulse),  32'(m_wrap));
        check("match_pulse", 32'(bus.match_pulse), 32'(m_match));
        check("step_err",    32'(bus.step_err),    32'(m_step));
        check("ovf_err",     32'(bus.ovf_err),     32'(m_ovf));
        if (bus.wrap_pulse === 1'b1)  wrap_seen++;
        if (bus.match_pulse === 1'b1) match_seen++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    // q_in changes at a random point inside the cycle, away from the edge.
    task automatic set_q(input int v);
        #($urandom_range(0, 3));
        bus.q_in = WIDTH'(v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        hold(2);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        bus.q_in = '0;
        bus.enable = 1'b1;
        bus.cmp_val = 12'hFFF;
        bus.clr_err = 1'b0;
        #2;

        // Reset, q_in held at 0: first acceptance on the fourth edge after release
        do_reset();
        hold(6);
        check("first_accept", 32'(bus.count_valid), 32'd1);

        // Unit steps 0..15 then 0: one wrap, no step error
        wrap_seen = 0;
        for (int v = 1; v <= 16; v++) begin
            set_q(v % 16);
            hold(6);
        end
        check("wrap_once", 32'(wrap_seen), 32'd1);
        check("count_16", 32'(bus.count_out), 32'h010);

        // Glitch 5 -> 7 (one cycle) -> 6: 7 never accepted
        set_q(5);
        do_reset();
        hold(6);
        set_q(7);
        tick();
        set_q(6);
        hold(6);
        check("glitch_skip", 32'(bus.count_out), 32'h006);

        // Bad steps and clr_err interaction
        set_q(3); hold(6);
        bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;
        set_q(6); hold(6);
        check("bad_step_set", 32'(bus.step_err), 32'd1);
        bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;
        hold(1);
        check("clr_step", 32'(bus.step_err), 32'd0);
        bus.clr_err = 1'b1;
        set_q(9);
        hold(6);
        bus.clr_err = 1'b0;
        hold(2);

        // Match on 0x012, no repeat while held
        set_q(15);
        do_reset();
        bus.cmp_val = 12'h012;
        hold(6);
        match_seen = 0;
        for (int v = 0; v <= 2; v++) begin
            set_q(v);
            hold(6);
        end
        hold(10);
        check("match_once", 32'(match_seen), 32'd1);
        check("match_cnt", 32'(bus.count_out), 32'h012);

        // Drive ext to 0xFF, then wrap 15 -> 0 to overflow
        bus.cmp_val = 12'h000;
        set_q(0);
        do_reset();
        hold(5);
        for (int k = 0; k < 255; k++) begin
            set_q(8); hold(5);
            set_q(0); hold(5);
        end
        check("ext_ff", 32'(bus.count_out), 32'hFF0);
        set_q(15); hold(5);
        set_q(0);  hold(5);
        check("ovf_set", 32'(bus.ovf_err), 32'd1);
        check("ovf_cnt", 32'(bus.count_out), 32'h000);

        // Reset mid-window discards the pending value
        set_q(5);
        hold(2);
        do_reset();
        check("rst_clear", 32'(bus.count_valid), 32'd0);
        hold(6);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            bus.enable  = ($urandom_range(0, 3) != 0);
            bus.clr_err = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0)
                bus.cmp_val = 12'(m_ext * 16 + $urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end
            set_q($urandom_range(0, 15));
            hold($urandom_range(1, 6));
        end
        bus.clr_err = 1'b0;
        hold(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
